// File: rtl/feature_access_pkg.sv
// Shared constants and helpers for the feature access arbiter.
package feature_access_pkg;

    localparam int unsigned FEAT_NONE = 0;

    // Session state encoding
    localparam logic [1:0] ST_IDLE         = 2'd0;
    localparam logic [1:0] ST_HOLD         = 2'd1;
    localparam logic [1:0] ST_WAIT_RELEASE = 2'd2;

    // Widest busy vector the decode helper can produce (FEAT_W up to 5)
    localparam int unsigned MAX_FEATS = 32;

    // Feature code k maps to bit k-1; code 0 decodes to all zeros
    function automatic logic [MAX_FEATS-1:0] feat_onehot(input int unsigned code);
        logic [MAX_FEATS-1:0] oh;
        oh = '0;
        if (code != FEAT_NONE && code <= MAX_FEATS) begin
            oh = {{(MAX_FEATS-1){1'b0}}, 1'b1} << (code - 1);
        end
        return oh;
    endfunction

    // Distance of idx from the round-robin pointer; smaller wins
    function automatic int unsigned rr_rank(input int unsigned idx, input int unsigned ptr,
                                            input int unsigned n);
        return (idx + n - ptr) % n;
    endfunction

endpackage

// File: rtl/feature_session_fsm.sv
// One entry interface's session: IDLE -> HOLD -> (IDLE | WAIT_RELEASE).
module feature_session_fsm
    import feature_access_pkg::*;
#(
    parameter int unsigned USER_W      = 3,
    parameter int unsigned FEAT_W      = 3,
    parameter int unsigned HOLD_CYCLES = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              win_i,
    input  logic              req_valid_i,
    input  logic              perm_ok_i,
    input  logic [USER_W-1:0] req_user_i,
    input  logic [FEAT_W-1:0] req_feat_i,
    output logic [1:0]        state_o,
    output logic              grant_o,
    output logic [FEAT_W-1:0] grant_feat_o,
    output logic              timeout_pulse_o
);

    localparam int unsigned CntW = (HOLD_CYCLES > 0) ? $clog2(HOLD_CYCLES + 1) : 1;

    logic [1:0]        state_q, state_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [USER_W-1:0] user_q, user_d;
    logic [FEAT_W-1:0] feat_q, feat_d;
    logic              timeout_q, timeout_d;
    logic              release_req;
    logic              timeout_hit;

    // Next-state: a release condition always beats a coinciding timeout
    always_comb begin
        release_req = !req_valid_i || !perm_ok_i || (req_feat_i != feat_q) ||
                      (req_user_i != user_q);
        timeout_hit = (HOLD_CYCLES != 0) && (cnt_q == CntW'(HOLD_CYCLES - 1));
        state_d     = state_q;
        cnt_d       = cnt_q;
        user_d      = user_q;
        feat_d      = feat_q;
        timeout_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (win_i) begin
                    state_d = ST_HOLD;
                    cnt_d   = '0;
                    user_d  = req_user_i;
                    feat_d  = req_feat_i;
                end
            end
            ST_HOLD: begin
                if (release_req) begin
                    state_d = ST_IDLE;
                end else if (timeout_hit) begin
                    state_d   = ST_WAIT_RELEASE;
                    timeout_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_WAIT_RELEASE: begin
                if (!req_valid_i) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Session registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            user_q    <= '0;
            feat_q    <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            user_q    <= user_d;
            feat_q    <= feat_d;
            timeout_q <= timeout_d;
        end
    end

    // Outputs derived purely from registered state
    always_comb begin
        state_o         = state_q;
        grant_o         = (state_q == ST_HOLD);
        grant_feat_o    = grant_o ? feat_q : '0;
        timeout_pulse_o = timeout_q;
    end

endmodule

// File: rtl/feature_access_arbiter.sv
// Round-robin feature arbiter over NUM_IF entry interfaces with timed sessions.
module feature_access_arbiter
    import feature_access_pkg::*;
#(
    parameter int unsigned NUM_IF      = 2,
    parameter int unsigned USER_W      = 3,
    parameter int unsigned FEAT_W      = 3,
    parameter int unsigned HOLD_CYCLES = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_IF-1:0]        req_valid,
    input  logic [NUM_IF*USER_W-1:0] req_user,
    input  logic [NUM_IF*FEAT_W-1:0] req_feat,
    input  logic [NUM_IF-1:0]        perm_ok,
    output logic [NUM_IF-1:0]        grant,
    output logic [NUM_IF*FEAT_W-1:0] grant_feat,
    output logic [2**FEAT_W-2:0]     feat_busy,
    output logic [NUM_IF-1:0]        timeout_pulse,
    output logic [USER_W-1:0]        disp_user,
    output logic                     disp_valid
);

    localparam int unsigned NumFeat = 2**FEAT_W - 1;
    localparam int unsigned PtrW    = $clog2(NUM_IF);

    logic [1:0]        ch_state [NUM_IF];
    logic [NUM_IF-1:0] eligible;
    logic [NUM_IF-1:0] win;
    logic [PtrW-1:0]   rr_ptr_q, rr_ptr_d;
    logic [PtrW-1:0]   disp_idx_q, disp_idx_d;
    logic [USER_W-1:0] disp_user_q, disp_user_d;

    for (genvar g = 0; g < NUM_IF; g++) begin : g_ch
        feature_session_fsm #(
            .USER_W      (USER_W),
            .FEAT_W      (FEAT_W),
            .HOLD_CYCLES (HOLD_CYCLES)
        ) u_fsm (
            .clk             (clk),
            .rst             (rst),
            .win_i           (win[g]),
            .req_valid_i     (req_valid[g]),
            .perm_ok_i       (perm_ok[g]),
            .req_user_i      (req_user[g*USER_W +: USER_W]),
            .req_feat_i      (req_feat[g*FEAT_W +: FEAT_W]),
            .state_o         (ch_state[g]),
            .grant_o         (grant[g]),
            .grant_feat_o    (grant_feat[g*FEAT_W +: FEAT_W]),
            .timeout_pulse_o (timeout_pulse[g])
        );
    end

    // Busy vector and eligibility, both from registered session state
    always_comb begin
        logic [MAX_FEATS-1:0] oh;
        logic [MAX_FEATS-1:0] busy_all;
        busy_all = '0;
        for (int i = 0; i < NUM_IF; i++) begin
            busy_all = busy_all | feat_onehot(32'(grant_feat[i*FEAT_W +: FEAT_W]));
        end
        feat_busy = busy_all[NumFeat-1:0];
        for (int i = 0; i < NUM_IF; i++) begin
            oh = feat_onehot(32'(req_feat[i*FEAT_W +: FEAT_W]));
            eligible[i] = (ch_state[i] == ST_IDLE) && req_valid[i] && perm_ok[i] &&
                          (req_feat[i*FEAT_W +: FEAT_W] != '0) && ((oh & busy_all) == '0);
        end
    end

    // Per-feature round-robin; pointer follows the lowest contended feature
    always_comb begin
        int unsigned cnt;
        logic        found;
        win      = '0;
        rr_ptr_d = rr_ptr_q;
        found    = 1'b0;
        for (int i = 0; i < NUM_IF; i++) begin
            win[i] = eligible[i];
            for (int j = 0; j < NUM_IF; j++) begin
                if (j != i && eligible[j] &&
                    req_feat[j*FEAT_W +: FEAT_W] == req_feat[i*FEAT_W +: FEAT_W] &&
                    rr_rank(j, 32'(rr_ptr_q), NUM_IF) < rr_rank(i, 32'(rr_ptr_q), NUM_IF)) begin
                    win[i] = 1'b0;
                end
            end
        end
        for (int k = 1; k <= int'(NumFeat); k++) begin
            cnt = 0;
            for (int j = 0; j < NUM_IF; j++) begin
                if (eligible[j] && 32'(req_feat[j*FEAT_W +: FEAT_W]) == k) cnt = cnt + 1;
            end
            if (!found && cnt >= 2) begin
                found = 1'b1;
                for (int j = 0; j < NUM_IF; j++) begin
                    if (win[j] && 32'(req_feat[j*FEAT_W +: FEAT_W]) == k) begin
                        rr_ptr_d = PtrW'((j + 1) % NUM_IF);
                    end
                end
            end
        end
    end

    // Display follows the lowest-index channel granted this cycle
    always_comb begin
        disp_user_d = disp_user_q;
        disp_idx_d  = disp_idx_q;
        for (int i = NUM_IF - 1; i >= 0; i--) begin
            if (win[i]) begin
                disp_user_d = req_user[i*USER_W +: USER_W];
                disp_idx_d  = PtrW'(i);
            end
        end
    end

    // Arbiter and display registers
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr_q    <= '0;
            disp_idx_q  <= '0;
            disp_user_q <= '0;
        end else begin
            rr_ptr_q    <= rr_ptr_d;
            disp_idx_q  <= disp_idx_d;
            disp_user_q <= disp_user_d;
        end
    end

    // Display outputs
    always_comb begin
        disp_user  = disp_user_q;
        disp_valid = (ch_state[disp_idx_q] == ST_HOLD);
    end

endmodule

// File: tb/tb_feature_access_arbiter.sv
// Directed and randomized checks of feature_access_arbiter against a session-level model.
module tb_feature_access_arbiter;

    localparam int N  = 2;
    localparam int UW = 3;
    localparam int FW = 3;
    localparam int HC = 8;
    localparam int NF = 7;

    logic          clk = 1'b0;
    logic          rst;
    logic [N-1:0]  req_valid, perm_ok;
    logic [N*UW-1:0] req_user;
    logic [N*FW-1:0] req_feat;
    logic [N-1:0]  grant, timeout_pulse;
    logic [N*FW-1:0] grant_feat;
    logic [NF-1:0] feat_busy;
    logic [UW-1:0] disp_user;
    logic          disp_valid;

    feature_access_arbiter #(
        .NUM_IF      (N),
        .USER_W      (UW),
        .FEAT_W      (FW),
        .HOLD_CYCLES (HC)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .req_valid     (req_valid),
        .req_user      (req_user),
        .req_feat      (req_feat),
        .perm_ok       (perm_ok),
        .grant         (grant),
        .grant_feat    (grant_feat),
        .feat_busy     (feat_busy),
        .timeout_pulse (timeout_pulse),
        .disp_user     (disp_user),
        .disp_valid    (disp_valid)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Session-level model: who holds what, how long, and who is locked out
    bit m_hold [N];
    bit m_wait [N];
    bit m_to   [N];
    int m_age  [N];
    int m_user [N];
    int m_feat [N];
    int m_ptr;
    int m_disp_user;
    int m_disp_ch;

    function automatic int in_feat(input int i);
        return int'(req_feat[i*FW +: FW]);
    endfunction

    function automatic int in_user(input int i);
        return int'(req_user[i*UW +: UW]);
    endfunction

    task automatic model_step();
        int  owner [NF+1];
        int  best  [NF+1];
        int  cnt   [NF+1];
        bit  elig  [N];
        bit  won   [N];
        int  f;
        int  contended;
        if (rst) begin
            for (int i = 0; i < N; i++) begin
                m_hold[i] = 0; m_wait[i] = 0; m_to[i] = 0;
                m_age[i] = 0; m_user[i] = 0; m_feat[i] = 0;
            end
            m_ptr = 0; m_disp_user = 0; m_disp_ch = 0;
            return;
        end
        for (int k = 0; k <= NF; k++) begin
            owner[k] = -1; best[k] = -1; cnt[k] = 0;
        end
        for (int i = 0; i < N; i++) if (m_hold[i]) owner[m_feat[i]] = i;
        for (int i = 0; i < N; i++) begin
            f = in_feat(i);
            elig[i] = !m_hold[i] && !m_wait[i] && req_valid[i] && perm_ok[i] && f != 0 &&
                      owner[f] < 0;
            if (elig[i]) begin
                cnt[f]++;
                if (best[f] < 0 || ((i - m_ptr + N) % N) < ((best[f] - m_ptr + N) % N))
                    best[f] = i;
            end
        end
        for (int i = 0; i < N; i++) won[i] = elig[i] && best[in_feat(i)] == i;
        contended = -1;
        for (int k = NF; k >= 1; k--) if (cnt[k] >= 2) contended = k;
        if (contended > 0) m_ptr = (best[contended] + 1) % N;
        for (int i = N - 1; i >= 0; i--) begin
            if (won[i]) begin
                m_disp_user = in_user(i);
                m_disp_ch   = i;
            end
        end
        for (int i = 0; i < N; i++) begin
            m_to[i] = 0;
            if (m_hold[i]) begin
                if (!req_valid[i] || !perm_ok[i] || in_feat(i) != m_feat[i] ||
                    in_user(i) != m_user[i]) begin
                    m_hold[i] = 0;
                end else if (m_age[i] == HC - 1) begin
                    m_hold[i] = 0; m_wait[i] = 1; m_to[i] = 1;
                end else begin
                    m_age[i]++;
                end
            end else if (m_wait[i]) begin
                if (!req_valid[i]) m_wait[i] = 0;
            end else if (won[i]) begin
                m_hold[i] = 1; m_age[i] = 0;
                m_user[i] = in_user(i); m_feat[i] = in_feat(i);
            end
        end
    endtask

    task automatic check_outputs();
        logic [N-1:0]    eg, eto;
        logic [N*FW-1:0] egf;
        logic [NF-1:0]   eb;
        eg = '0; eto = '0; egf = '0; eb = '0;
        for (int i = 0; i < N; i++) begin
            eg[i]  = m_hold[i];
            eto[i] = m_to[i];
            if (m_hold[i]) begin
                egf[i*FW +: FW] = FW'(m_feat[i]);
                eb = eb | (NF'(1) << (m_feat[i] - 1));
            end
        end
        check_eq("grant", 64'(grant), 64'(eg));
        check_eq("grant_feat", 64'(grant_feat), 64'(egf));
        check_eq("feat_busy", 64'(feat_busy), 64'(eb));
        check_eq("timeout_pulse", 64'(timeout_pulse), 64'(eto));
        check_eq("disp_user", 64'(disp_user), 64'(m_disp_user));
        check_eq("disp_valid", 64'(disp_valid), 64'(m_hold[m_disp_ch]));
        check_eq("rr_ptr", 64'(dut.rr_ptr_q), 64'(m_ptr));
    endtask

    task automatic step();
        @(posedge clk);
        model_step();
        #1;
        check_outputs();
    endtask

    task automatic set_ch(input int i, input bit v, input int u, input int f, input bit p);
        req_valid[i] = v;
        perm_ok[i]   = p;
        req_user[i*UW +: UW] = UW'(u);
        req_feat[i*FW +: FW] = FW'(f);
    endtask

    task automatic clear_all();
        for (int i = 0; i < N; i++) set_ch(i, 0, 0, 0, 1);
        step();
        step();
    endtask

    // Count grant-high cycles and pulses for channel ch after it was just granted
    task automatic count_hold(input int ch, output int gc, output int pc);
        gc = 0; pc = 0;
        for (int c = 0; c < 12; c++) begin
            if (grant[ch]) gc++;
            if (timeout_pulse[ch]) pc++;
            step();
        end
    endtask

    int gc, pc;

    initial begin
        rst = 1'b1;
        req_valid = '0; perm_ok = '0; req_user = '0; req_feat = '0;
        step();
        check_eq("reset_grant", 64'(grant), 64'd0);
        check_eq("reset_busy", 64'(feat_busy), 64'd0);
        step();
        rst = 1'b0;

        // Single request
        set_ch(0, 1, 5, 3, 1);
        step();
        check_eq("t1_grant", 64'(grant), 64'b01);
        check_eq("t1_gfeat0", 64'(grant_feat[FW-1:0]), 64'd3);
        check_eq("t1_busy", 64'(feat_busy), 64'b0000100);
        check_eq("t1_disp_user", 64'(disp_user), 64'd5);
        check_eq("t1_disp_valid", 64'(disp_valid), 64'd1);
        clear_all();

        // Contention on one feature, then alternation
        set_ch(0, 1, 1, 5, 1);
        set_ch(1, 1, 2, 5, 1);
        step();
        check_eq("t2_grant_a", 64'(grant), 64'b01);
        check_eq("t2_ptr", 64'(dut.rr_ptr_q), 64'd1);
        clear_all();
        set_ch(0, 1, 1, 5, 1);
        set_ch(1, 1, 2, 5, 1);
        step();
        check_eq("t2_grant_b", 64'(grant), 64'b10);
        check_eq("t2_disp_user", 64'(disp_user), 64'd2);
        clear_all();

        // Different features granted together
        set_ch(0, 1, 3, 2, 1);
        set_ch(1, 1, 4, 6, 1);
        step();
        check_eq("t3_grant", 64'(grant), 64'b11);
        check_eq("t3_busy", 64'(feat_busy), 64'b0100010);
        check_eq("t3_ptr", 64'(dut.rr_ptr_q), 64'd0);
        check_eq("t3_disp_user", 64'(disp_user), 64'd3);
        clear_all();

        // Timeout and lockout
        set_ch(0, 1, 6, 1, 1);
        step();
        count_hold(0, gc, pc);
        check_eq("t4_hold_cycles", 64'(gc), 64'd8);
        check_eq("t4_pulses", 64'(pc), 64'd1);
        check_eq("t4_no_regrant", 64'(grant[0]), 64'd0);
        set_ch(0, 0, 6, 1, 1);
        step();
        set_ch(0, 1, 6, 1, 1);
        step();
        check_eq("t4_regrant", 64'(grant[0]), 64'd1);
        clear_all();

        // Blocking and release hand-over
        set_ch(0, 1, 1, 4, 1);
        step();
        set_ch(1, 1, 2, 4, 1);
        step();
        check_eq("t5_blocked", 64'(grant), 64'b01);
        step();
        check_eq("t5_still_blocked", 64'(grant), 64'b01);
        perm_ok[0] = 1'b0;
        step();
        check_eq("t5_release", 64'(grant), 64'b00);
        step();
        check_eq("t5_handover", 64'(grant), 64'b10);
        clear_all();

        // Reset mid-session
        set_ch(0, 1, 3, 7, 1);
        set_ch(1, 1, 4, 7, 1);
        step();
        check_eq("t6_grant", 64'(grant), 64'b01);
        step(); step(); step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        check_eq("t6_rst_grant", 64'(grant), 64'd0);
        check_eq("t6_rst_busy", 64'(feat_busy), 64'd0);
        check_eq("t6_rst_disp", 64'(disp_user), 64'd0);
        check_eq("t6_rst_ptr", 64'(dut.rr_ptr_q), 64'd0);
        step();
        check_eq("t6_fresh_grant", 64'(grant), 64'b01);
        count_hold(0, gc, pc);
        check_eq("t6_hold_cycles", 64'(gc), 64'd8);
        clear_all();

        // Randomized sticky stimulus
        for (int c = 0; c < 3000; c++) begin
            rst = ($urandom_range(0, 299) == 0);
            for (int i = 0; i < N; i++) begin
                if ($urandom_range(0, 7) == 0) begin
                    set_ch(i, $urandom_range(0, 5) != 0, int'($urandom_range(0, 3)),
                           int'($urandom_range(0, 3)), $urandom_range(0, 9) != 0);
                end
            end
            step();
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
